// File: rtl/conv_pkg.sv
// Shared definitions for the conv tile output path: size defaults, index-width
// helpers and the streamer state encoding.
package conv_pkg;

  localparam int DEFAULT_OUTPUT_TILE_SIZE = 2;
  localparam int DEFAULT_OUTPUT_BIT_WIDTH = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Valid (no padding, stride 1) convolution shrinks the tile by kernel-1.
  function automatic int out_tile_edge(input int in_tile_size, input int kernel_size);
    return in_tile_size - kernel_size + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_tile_streamer_if.sv
// Tile-in / element-out bus of conv_tile_streamer; slave is the streamer side.
interface conv_tile_streamer_if #(
  parameter int N = conv_pkg::DEFAULT_OUTPUT_TILE_SIZE,
  parameter int W = conv_pkg::DEFAULT_OUTPUT_BIT_WIDTH
) ();
  localparam int IW = conv_pkg::idx_width(N);

  logic [N*N*W-1:0] tile_data;
  logic             tile_valid;
  logic             tile_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_row;
  logic [IW-1:0]    out_col;
  logic             out_last;
  logic             busy;

  modport slave (
    input  tile_data, tile_valid, out_ready,
    output tile_ready, out_data, out_valid, out_row, out_col, out_last, busy
  );

  modport master (
    output tile_data, tile_valid, out_ready,
    input  tile_ready, out_data, out_valid, out_row, out_col, out_last, busy
  );
endinterface

// File: rtl/conv_tile_buf.sv
// Two-entry FIFO of packed tiles: head is the active tile, second entry the pending one.
module conv_tile_buf #(
  parameter int TW = 96
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [TW-1:0] push_data,
  input  logic          pop,
  output logic [TW-1:0] head,
  output logic          full,
  output logic          empty
);

  logic [TW-1:0] mem_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == 2'd2);
  assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/conv_tile_streamer.sv
// Serialises packed conv output tiles one element per beat, double-buffered.
// Define CONV_STREAM_RELU_EN to clamp negative elements to zero at the output mux.
module conv_tile_streamer
  import conv_pkg::*;
#(
  parameter int OUTPUT_TILE_SIZE = DEFAULT_OUTPUT_TILE_SIZE,
  parameter int OUTPUT_BIT_WIDTH = DEFAULT_OUTPUT_BIT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  conv_tile_streamer_if.slave bus
);

  localparam int N  = OUTPUT_TILE_SIZE;
  localparam int W  = OUTPUT_BIT_WIDTH;
  localparam int NN = N * N;
  localparam int CW = idx_width(NN);
  localparam int IW = idx_width(N);
  localparam int TW = NN * W;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

  stream_state_e state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          accept;
  logic          beat;
  logic          at_last;
  logic          pop;
  logic          buf_full;
  logic          buf_empty;
  logic [TW-1:0] head_tile;
  logic [W-1:0]  elem [NN];
  logic [W-1:0]  sel_elem;
  logic [W-1:0]  shaped_elem;
  logic          streaming;

  assign accept  = bus.tile_valid & bus.tile_ready;
  assign beat    = (state_reg == STREAM) & bus.out_ready;
  assign at_last = (cnt_reg == LAST_IDX);

  conv_tile_buf #(
    .TW(TW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_data(bus.tile_data),
    .pop      (pop),
    .head     (head_tile),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A tile accepted on the final beat of the last buffered tile becomes the
  // new head directly, so streaming continues without a bubble.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = STREAM;
          cnt_next   = '0;
        end
      end
      STREAM: begin
        if (beat) begin
          if (at_last) begin
            pop      = 1'b1;
            cnt_next = '0;
            if (!(buf_full || accept)) begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_elem
      assign elem[gi] = head_tile[gi*W +: W];
    end
  endgenerate

  assign sel_elem = elem[cnt_reg];

`ifdef CONV_STREAM_RELU_EN
  assign shaped_elem = sel_elem[W-1] ? '0 : sel_elem;
`else
  assign shaped_elem = sel_elem;
`endif

  assign streaming      = (state_reg == STREAM);
  assign bus.tile_ready = !buf_full;
  assign bus.out_valid  = streaming;
  assign bus.out_data   = streaming ? shaped_elem : '0;
  assign bus.out_row    = streaming ? IW'(cnt_reg / N) : '0;
  assign bus.out_col    = streaming ? IW'(cnt_reg % N) : '0;
  assign bus.out_last   = streaming & at_last;
  assign bus.busy       = !buf_empty;

endmodule

// File: tb/tb_conv_tile_streamer.sv
// Directed bench for conv_tile_streamer (N=2, W=24): tile vector table plus
// hand-written back-to-back, backpressure and mid-stream reset sequences.
module tb_conv_tile_streamer;

  localparam int N = 2;
  localparam int W = 24;

  logic clk;
  logic reset;

  conv_tile_streamer_if #(.N(N), .W(W)) bus ();

  conv_tile_streamer #(
    .OUTPUT_TILE_SIZE(N),
    .OUTPUT_BIT_WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [23:0] din  [4];
    logic [23:0] dexp [4];
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [23:0] d [4]);
    bus.tile_data  = {d[3], d[2], d[1], d[0]};
    bus.tile_valid = 1'b1;
  endtask

  task automatic check_beat(input string tag, input logic [23:0] exp_data, input int k);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data),  32'(exp_data));
    check({tag, "_row"},   32'(bus.out_row),   32'(k / N));
    check({tag, "_col"},   32'(bus.out_col),   32'(k % N));
    check({tag, "_last"},  32'(bus.out_last),  32'(k == 3));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_valid"}, 32'(bus.out_valid),  32'd0);
    check({tag, "_idle_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_idle_ready"}, 32'(bus.tile_ready), 32'd1);
  endtask

  // Offer one tile into an idle block, drain it at full rate, expect idle after.
  task automatic run_tile(input vec_t v);
    @(negedge clk);
    check({v.name, "_ready_in"}, 32'(bus.tile_ready), 32'd1);
    offer(v.din);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.tile_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check_beat($sformatf("%s_k%0d", v.name, b), v.dexp[b], b);
    end
    @(negedge clk);
    check_idle(v.name);
    $display("tile %s: 4 beats drained", v.name);
  endtask

  vec_t vecs [3];
  vec_t tile_a, tile_b, tile_r, tile_post;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].name = "basic";
    vecs[0].din  = '{24'h000001, 24'hFFFFFE, 24'h000003, 24'h7FFFFF};
    vecs[0].dexp = '{24'h000001, 24'hFFFFFE, 24'h000003, 24'h7FFFFF};
    vecs[1].name = "signs";
    vecs[1].din  = '{24'hFFFFFF, 24'h000004, 24'h800000, 24'h000000};
`ifdef CONV_STREAM_RELU_EN
    vecs[1].dexp = '{24'h000000, 24'h000004, 24'h000000, 24'h000000};
`else
    vecs[1].dexp = '{24'hFFFFFF, 24'h000004, 24'h800000, 24'h000000};
`endif
    vecs[2].name = "mixed";
    vecs[2].din  = '{24'h123456, 24'h800001, 24'h000000, 24'h654321};
`ifdef CONV_STREAM_RELU_EN
    vecs[2].dexp = '{24'h123456, 24'h000000, 24'h000000, 24'h654321};
`else
    vecs[2].dexp = '{24'h123456, 24'h800001, 24'h000000, 24'h654321};
`endif
    tile_a.name = "A";    tile_a.din = '{24'd10, 24'd11, 24'd12, 24'd13}; tile_a.dexp = tile_a.din;
    tile_b.name = "B";    tile_b.din = '{24'd20, 24'd21, 24'd22, 24'd23}; tile_b.dexp = tile_b.din;
    tile_r.name = "R";    tile_r.din = '{24'd1, 24'd2, 24'd3, 24'd4};     tile_r.dexp = tile_r.din;
    tile_post.name = "post_reset";
    tile_post.din  = '{24'd5, 24'd6, 24'd7, 24'd8};
    tile_post.dexp = tile_post.din;

    reset          = 1'b0;
    bus.tile_data  = '0;
    bus.tile_valid = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_last",   32'(bus.out_last),   32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'd0);
    check("rst_out_row",    32'(bus.out_row),    32'd0);
    check("rst_out_col",    32'(bus.out_col),    32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_tile_ready", 32'(bus.tile_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_tile(vecs[i]);
    end

    // Back-to-back: B offered while A streams, 8 beats with no bubble
    @(negedge clk);
    offer(tile_a.din);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.tile_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      check_beat($sformatf("b2b_%0d", b), (b < 4) ? tile_a.din[b] : tile_b.din[b-4], b % 4);
      if (b == 0) begin
        check("b2b_ready_one_full", 32'(bus.tile_ready), 32'd1);
        offer(tile_b.din);
      end else if (b == 1) begin
        check("b2b_ready_both_full", 32'(bus.tile_ready), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        bus.tile_valid = 1'b0;
      end else if (b == 4) begin
        check("b2b_ready_after_promote", 32'(bus.tile_ready), 32'd1);
      end
    end
    @(negedge clk);
    check_idle("b2b");
    $display("tile A+B: 8 beats back-to-back");

    // Backpressure on element k1 for 3 cycles
    @(negedge clk);
    offer(tile_a.din);
    @(posedge clk);
    #1 bus.tile_valid = 1'b0;
    @(negedge clk);
    check_beat("bp_k0", 24'd10, 0);
    @(negedge clk);
    check_beat("bp_k1", 24'd11, 1);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_beat($sformatf("bp_hold%0d", s), 24'd11, 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_beat("bp_k2", 24'd12, 2);
    @(negedge clk);
    check_beat("bp_k3", 24'd13, 3);
    @(negedge clk);
    check_idle("bp");
    $display("tile backpressure: k1 held 3 cycles");

    // Reset mid-tile after two beats, with a second tile pending
    @(negedge clk);
    offer(tile_r.din);
    @(posedge clk);
    #1 offer(tile_a.din);
    @(negedge clk);
    check_beat("mr_k0", 24'd1, 0);
    @(posedge clk);
    #1 bus.tile_valid = 1'b0;
    @(negedge clk);
    check_beat("mr_k1", 24'd2, 1);
    check("mr_busy_pending", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mr_out_valid",  32'(bus.out_valid),  32'd0);
    check("mr_busy",       32'(bus.busy),       32'd0);
    check("mr_tile_ready", 32'(bus.tile_ready), 32'd1);
    check("mr_out_data",   32'(bus.out_data),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mr_released");
    $display("tile R: reset after 2 beats");
    run_tile(tile_post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_tile_streamer.md
Name: conv_tile_streamer

Overview:
- Output-side reader for the convolution tile engine's flattened result bus. Captures one packed output tile, then serialises it one element per beat over a valid/ready stream toward pooling, writeback or the accumulation buffer.
- Holds up to two tiles: one active plus one pending. The conv engine can therefore hand over the next tile while the current one drains.

Parameters:
- OUTPUT_TILE_SIZE, 2, output tile edge length (N); tile holds N*N elements.
- OUTPUT_BIT_WIDTH, 24, signed element width (W); matches the conv engine's INPUT_DATA_WIDTH + KERNEL_DATA_WIDTH + 8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- tile_data  in  N*N*W  packed signed tile; element k = bits [k*W +: W], k = i*N + j (row-major, row i outer)
- tile_valid  in  1  tile_data is valid
- tile_ready  out  1  block can accept a tile this cycle
- out_data  out  W  current signed element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_row  out  clog2(N) (min 1)  row index i of current element
- out_col  out  clog2(N) (min 1)  column index j of current element
- out_last  out  1  current element is the tile's final element (k = N*N-1)
- busy  out  1  active or pending buffer occupied

Behaviour:
- Reset (async, reset=0) values:
  - out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0.
  - tile_ready=1, both buffers empty, element counter=0.
- Tile handshake:
  - A tile is taken on a clk edge with tile_valid & tile_ready.
  - tile_ready = !pending_full (combinational from state, not from tile_valid).
  - If the active buffer is empty, the accepted tile loads into active. Otherwise it loads into pending.
- States:
  - IDLE: active empty, out_valid=0. On accept -> STREAM, counter=0.
  - STREAM: out_valid=1; out_data = active element[counter]; out_row/out_col/out_last derived from counter.
- Element advance and tile-end transitions:
  - In STREAM, each out_valid & out_ready beat increments counter.
  - On the beat with counter = N*N-1:
    - if pending is full, pending moves to active, counter=0, stay STREAM;
    - else if a tile is accepted that same cycle, it loads directly into active, counter=0, stay STREAM;
    - else go to IDLE.
- Latency and throughput:
  - First element is valid the cycle after tile acceptance (1-cycle latency).
  - Sustained throughput is one element per cycle with out_ready held high, with no bubble between tiles when pending is full.
- Output stability: out_data, out_row, out_col and out_last hold stable while out_valid=1 and out_ready=0.
- Simultaneous tile accept and pending→active promotion in the same cycle: the new tile goes into pending. Ordering is strictly FIFO.
- Width rules:
  - No arithmetic on data; elements pass bit-exact.
  - The counter is clog2(N*N) bits wide (min 1) and wraps to 0 only through the tile-end transition.
  - N=1: out_last is high on every element.
- Reset mid-stream drops both buffers immediately. No partial tile resumes after reset release.

Optional Feature:
- CONV_STREAM_RELU_EN defined: out_data = 0 when the selected element's sign bit is 1, otherwise the element unchanged. Applied combinationally at the output mux; stored buffers stay raw.
- Undefined: out_data is the raw signed element.

Decomposition:
- Shared package conv_pkg holds:
  - OUTPUT_TILE_SIZE and OUTPUT_BIT_WIDTH defaults;
  - a function computing the output tile edge from input tile and kernel sizes;
  - the element-index width function (clog2 with min 1);
  - the state encoding (IDLE, STREAM).
- One sub-module is natural: conv_tile_buf, a 2-entry tile FIFO holding full packed tiles and exposing full/empty and the head tile. The streamer keeps the counter, FSM and output mux.

Test Plan (N=2, W=24):
- Single tile, elements k0..k3 = 1, -2 (0xFFFFFE), 3, 0x7FFFFF, out_ready=1 -> beats 1,0xFFFFFE,3,0x7FFFFF on 4 consecutive cycles starting 1 cycle after accept; (row,col) = (0,0),(0,1),(1,0),(1,1); out_last only on beat 4; then out_valid=0.
- Back-to-back tiles A={10,11,12,13}, B={20,21,22,23}, B offered while A streams -> B accepted into pending; 8 contiguous beats 10..13,20..23 with no bubble; tile_ready=0 while both buffers are full.
- Backpressure: out_ready low for 3 cycles on element k1 -> out_data holds 11 and out_row/out_col hold (0,1) for all 3 cycles; stream resumes with 12 when out_ready returns high.
- Reset asserted (reset=0) mid-tile after 2 beats -> out_valid=0, busy=0 and tile_ready=1 asynchronously; after release, a new tile {5,6,7,8} streams from k0=5.
- CONV_STREAM_RELU_EN defined with tile {-1, 4, 0x800000, 0} -> beats 0, 4, 0, 0; undefined -> 0xFFFFFF, 4, 0x800000, 0.
